simt_stack_mw: RTL and testbench
================================

Name: simt_stack_mw

Overview:
Multi-warp SIMT reconvergence stack: one independent stack per warp, held in a single banked register array. It sits in the CS stage beside the warp scheduler. It serves push/modify/pop/read commands tagged with a warp ID, plus a two-cycle DIVERGE command that pushes both branch paths atomically. Read responses are registered, and protocol errors are reported instead of silently dropped.

Parameters:
NUM_WARPS, 8, number of independent per-warp stacks (power of 2, ≥2)
STACK_DEPTH, 32, entries per warp stack (power of 2, ≥2)
PC_WIDTH, 64, width of next_pc and reconvergence_pc
THREAD_WIDTH, 256, active-mask width
WID_W, $clog2(NUM_WARPS), warp ID width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  3  0 NOP, 1 PUSH, 2 MODIFY, 3 POP, 4 READ, 5 DIVERGE; 6-7 reserved (treated as NOP)
cmd_warp  in  WID_W  target warp
cmd_next_pc  in  PC_WIDTH  entry next PC (not-taken path for DIVERGE)
cmd_reconv_pc  in  PC_WIDTH  entry reconvergence PC (shared by both DIVERGE entries)
cmd_mask  in  THREAD_WIDTH  entry active mask (not-taken path for DIVERGE)
cmd_taken_pc  in  PC_WIDTH  DIVERGE taken-path PC
cmd_taken_mask  in  THREAD_WIDTH  DIVERGE taken-path mask
rsp_valid  out  1  one-cycle pulse; read data valid
rsp_warp  out  WID_W  warp of response
rsp_next_pc  out  PC_WIDTH  top next PC
rsp_reconv_pc  out  PC_WIDTH  top reconvergence PC
rsp_mask  out  THREAD_WIDTH  top active mask
rsp_at_reconv  out  1  rsp_next_pc == rsp_reconv_pc
warp_empty  out  NUM_WARPS  per-warp empty flag
warp_full  out  NUM_WARPS  per-warp full flag
err_valid  out  1  one-cycle error pulse
err_code  out  2  1 overflow, 2 underflow, 3 modify/read on empty

Behaviour:
- Reset (async assert, sync release): all pointers 0; warp_empty all 1s; warp_full all 0s; rsp_* 0; err_* 0; FSM in IDLE. Entry storage is not reset.
- Per-warp pointer sp[w] is 0..STACK_DEPTH, so the counter is $clog2(STACK_DEPTH)+1 bits wide. empty = (sp==0); full = (sp==STACK_DEPTH). Flags are registered and reflect the update in the cycle after acceptance.
- FSM states are IDLE and DIV2. cmd_ready = (state==IDLE).
- PUSH: if not full, write entry at sp and increment sp. If full: no state change; err 1.
- MODIFY: if not empty, overwrite entry sp-1 in all three fields. If empty: no change; err 3.
- POP: if not empty, decrement sp. If empty: no change; err 2.
- READ: the next cycle gives rsp_valid=1 with the top entry of cmd_warp as it stood at acceptance. If empty: rsp_valid=0; err 3.
- DIVERGE, cycle 1 (accept): requires sp ≤ STACK_DEPTH-2, else no change and err 1. Writes {next_pc, reconv_pc, mask} at sp and increments sp. Latches warp ID, taken_pc, taken_mask and reconv_pc, then goes to DIV2.
- DIVERGE, cycle 2 (DIV2): writes {taken_pc, reconv_pc, taken_mask} and increments sp, returns to IDLE. cmd_ready is 0 during this cycle. The taken path is on top.
- A command targeting warp w affects only warp w; other warps' data and flags never change.
- Latency:
  - READ: 1 cycle from acceptance to rsp_valid.
  - Pointer-changing commands: flags update 1 cycle after acceptance.
  - DIVERGE: flags final 2 cycles after acceptance.
- Back-to-back: READ issued the cycle after a PUSH or MODIFY to the same warp returns the new data; no bubble is needed.
- Reserved ops: no state change, no error.
- Reset asserted mid-DIVERGE: the second push is abandoned; all stacks are empty after reset.

Optional Feature:
SIMT_STACK_MW_WATERMARK_EN
- Defined: adds output max_depth (NUM_WARPS × ($clog2(STACK_DEPTH)+1) bits), a per-warp high-water mark of sp. Reset to 0; updated whenever sp exceeds the stored value; never decreases except on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset → warp_empty=8'hFF, warp_full=8'h00, cmd_ready=1, rsp_valid=0, err_valid=0.
- PUSH warp 3 {0x1000, 0x2000, 1<<0}, then READ warp 3 → rsp_valid the next cycle with rsp_warp=3, PC=0x1000, reconv=0x2000, mask=0x1, rsp_at_reconv=0. warp_empty[3]=0 and all other warps' bits stay 1.
- DIVERGE warp 1 {next 0x1100, reconv 0x3000, mask 0x0F, taken 0x1200, taken_mask 0xF0} → cmd_ready=0 for one cycle. READ returns 0x1200/0xF0. After POP, READ returns 0x1100/0x0F. After a second POP, warp_empty[1]=1.
- Fill warp 0 with 32 PUSHes → warp_full[0]=1. A 33rd PUSH gives err_code=1 and the top is unchanged (entry 31). DIVERGE with sp=31 on a refilled-minus-one warp gives err_code=1.
- POP, MODIFY and READ on empty warp 5 → err_code 2, 3 and 3 respectively. sp stays 0 and no rsp_valid.
- MODIFY warp 2 top to {0x4000, 0x4000, 0xFF} → READ returns rsp_at_reconv=1. Assert rst_n=0 during DIV2 of a DIVERGE → all warp_empty bits are 1 immediately (asynchronously).

Source files
------------

// File: rtl/simt_stack_mw.sv
// simt_stack_mw: multi-warp SIMT reconvergence stack.
// One independent stack per warp, all held in one banked entry array.
// Commands: NOP, PUSH, MODIFY, POP, READ, and a two-cycle DIVERGE that
// pushes the not-taken path and then the taken path (taken ends on top).
// Optional feature macro: SIMT_STACK_MW_WATERMARK_EN adds a per-warp
// high-water mark output (max_depth).
module simt_stack_mw #(
   parameter int NUM_WARPS    = 8,
   parameter int STACK_DEPTH  = 32,
   parameter int PC_WIDTH     = 64,
   parameter int THREAD_WIDTH = 256,
   parameter int WID_W        = $clog2(NUM_WARPS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [2:0]              cmd_op,
   input  logic [WID_W-1:0]        cmd_warp,
   input  logic [PC_WIDTH-1:0]     cmd_next_pc,
   input  logic [PC_WIDTH-1:0]     cmd_reconv_pc,
   input  logic [THREAD_WIDTH-1:0] cmd_mask,
   input  logic [PC_WIDTH-1:0]     cmd_taken_pc,
   input  logic [THREAD_WIDTH-1:0] cmd_taken_mask,
   output logic                    rsp_valid,
   output logic [WID_W-1:0]        rsp_warp,
   output logic [PC_WIDTH-1:0]     rsp_next_pc,
   output logic [PC_WIDTH-1:0]     rsp_reconv_pc,
   output logic [THREAD_WIDTH-1:0] rsp_mask,
   output logic                    rsp_at_reconv,
   output logic [NUM_WARPS-1:0]    warp_empty,
   output logic [NUM_WARPS-1:0]    warp_full,
   output logic                    err_valid,
   output logic [1:0]              err_code
`ifdef SIMT_STACK_MW_WATERMARK_EN
   ,
   output logic [NUM_WARPS*($clog2(STACK_DEPTH)+1)-1:0] max_depth
`endif
);

   localparam int AW   = $clog2(STACK_DEPTH);
   localparam int SP_W = AW + 1;
   localparam logic [SP_W-1:0] SP_FULL    = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_DIV_MAX = SP_W'(STACK_DEPTH - 2);
   localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
   localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
   localparam logic [1:0] ERR_EMPTY     = 2'd3;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_PUSH    = 3'd1,
      OP_MODIFY  = 3'd2,
      OP_POP     = 3'd3,
      OP_READ    = 3'd4,
      OP_DIVERGE = 3'd5
   } op_t;

   typedef enum logic {IDLE, DIV2} state_t;

   typedef struct packed {
      logic [PC_WIDTH-1:0]     next_pc;
      logic [PC_WIDTH-1:0]     reconv_pc;
      logic [THREAD_WIDTH-1:0] mask;
   } entry_t;

   state_t                  state, state_nxt;
   logic [SP_W-1:0]         sp [NUM_WARPS];
   entry_t                  mem [NUM_WARPS][STACK_DEPTH];

   // Second half of a DIVERGE, captured at acceptance
   logic [WID_W-1:0]        div_warp;
   logic [PC_WIDTH-1:0]     div_taken_pc;
   logic [PC_WIDTH-1:0]     div_reconv_pc;
   logic [THREAD_WIDTH-1:0] div_taken_mask;

   logic                    accept;
   logic [SP_W-1:0]         cur_sp, cur_sp_dec, div_sp;
   entry_t                  top_entry;

   logic                    wr_en;
   logic [WID_W-1:0]        wr_warp;
   logic [AW-1:0]           wr_idx;
   entry_t                  wr_data;
   logic                    sp_en;
   logic [WID_W-1:0]        sp_warp;
   logic [SP_W-1:0]         sp_new;
   logic                    div_latch;
   logic                    rsp_set;
   logic                    err_set;
   logic [1:0]              err_code_d;

   assign cmd_ready  = (state == IDLE);
   assign accept     = cmd_valid && cmd_ready;
   assign cur_sp     = sp[cmd_warp];
   assign cur_sp_dec = cur_sp - SP_ONE;
   assign div_sp     = sp[div_warp];
   // Read sees any write committed on the previous edge, so READ right
   // after PUSH/MODIFY to the same warp needs no bubble.
   assign top_entry  = mem[cmd_warp][cur_sp_dec[AW-1:0]];

   // Command decode: next state, entry write, pointer update, response, error
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_nxt         = state;
      wr_en             = 1'b0;
      wr_warp           = cmd_warp;
      wr_idx            = cur_sp[AW-1:0];
      wr_data.next_pc   = cmd_next_pc;
      wr_data.reconv_pc = cmd_reconv_pc;
      wr_data.mask      = cmd_mask;
      sp_en             = 1'b0;
      sp_warp           = cmd_warp;
      sp_new            = cur_sp + SP_ONE;
      div_latch         = 1'b0;
      rsp_set           = 1'b0;
      err_set           = 1'b0;
      err_code_d        = ERR_NONE;

      case (state)
         IDLE: begin
            if (accept) begin
               case (op_t'(cmd_op))
                  OP_PUSH: begin
                     if (cur_sp == SP_FULL) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                     end else begin
                        wr_en = 1'b1;
                        sp_en = 1'b1;
                     end
                  end
                  OP_MODIFY: begin
                     if (cur_sp == '0) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_EMPTY;
                     end else begin
                        wr_en  = 1'b1;
                        wr_idx = cur_sp_dec[AW-1:0];
                     end
                  end
                  OP_POP: begin
                     if (cur_sp == '0) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_UNDERFLOW;
                     end else begin
                        sp_en  = 1'b1;
                        sp_new = cur_sp_dec;
                     end
                  end
                  OP_READ: begin
                     if (cur_sp == '0) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_EMPTY;
                     end else begin
                        rsp_set = 1'b1;
                     end
                  end
                  OP_DIVERGE: begin
                     // Both paths must fit, otherwise nothing is pushed
                     if (cur_sp > SP_DIV_MAX) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_OVERFLOW;
                     end else begin
                        wr_en     = 1'b1;
                        sp_en     = 1'b1;
                        div_latch = 1'b1;
                        state_nxt = DIV2;
                     end
                  end
                  default: ;
               endcase
            end
         end
         DIV2: begin
            wr_en             = 1'b1;
            wr_warp           = div_warp;
            wr_idx            = div_sp[AW-1:0];
            wr_data.next_pc   = div_taken_pc;
            wr_data.reconv_pc = div_reconv_pc;
            wr_data.mask      = div_taken_mask;
            sp_en             = 1'b1;
            sp_warp           = div_warp;
            sp_new            = div_sp + SP_ONE;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking (<=) to avoid ordering races between blocks.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the taken path for the DIV2 cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_warp       <= '0;
         div_taken_pc   <= '0;
         div_reconv_pc  <= '0;
         div_taken_mask <= '0;
      end else if (div_latch) begin
         div_warp       <= cmd_warp;
         div_taken_pc   <= cmd_taken_pc;
         div_reconv_pc  <= cmd_reconv_pc;
         div_taken_mask <= cmd_taken_mask;
      end
   end

   // Entry storage write
   always_ff @(posedge clk) begin
      // NOTE: entry storage has no reset; the pointers alone define what is valid.
      if (wr_en) mem[wr_warp][wr_idx] <= wr_data;
   end

   // Per-warp stack pointers and registered empty/full flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARPS; w++) sp[w] <= '0;
         warp_empty <= '1;
         warp_full  <= '0;
      end else if (sp_en) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (sp_warp == WID_W'(w)) begin
               sp[w]         <= sp_new;
               warp_empty[w] <= (sp_new == '0);
               warp_full[w]  <= (sp_new == SP_FULL);
            end
         end
      end
   end

   // Registered read response; data holds between responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid     <= 1'b0;
         rsp_warp      <= '0;
         rsp_next_pc   <= '0;
         rsp_reconv_pc <= '0;
         rsp_mask      <= '0;
         rsp_at_reconv <= 1'b0;
      end else begin
         rsp_valid <= rsp_set;
         if (rsp_set) begin
            rsp_warp      <= cmd_warp;
            rsp_next_pc   <= top_entry.next_pc;
            rsp_reconv_pc <= top_entry.reconv_pc;
            rsp_mask      <= top_entry.mask;
            rsp_at_reconv <= (top_entry.next_pc == top_entry.reconv_pc);
         end
      end
   end

   // One-cycle error pulse; code reads 0 when no error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         err_valid <= err_set;
         err_code  <= err_code_d;
      end
   end

`ifdef SIMT_STACK_MW_WATERMARK_EN
   // Per-warp high-water mark of the stack pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_depth <= '0;
      end else if (sp_en) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (sp_warp == WID_W'(w) && sp_new > max_depth[w*SP_W +: SP_W])
               max_depth[w*SP_W +: SP_W] <= sp_new;
         end
      end
   end
`endif

endmodule

// File: tb/tb_simt_stack_mw.sv
// tb_simt_stack_mw: directed self-checking bench for simt_stack_mw
// (default parameters, watermark feature off).
module tb_simt_stack_mw;

   localparam int NW = 8;
   localparam int SD = 32;
   localparam int PW = 64;
   localparam int TW = 256;
   localparam int WW = 3;

   localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_MODIFY = 3'd2,
                          OP_POP = 3'd3, OP_READ = 3'd4, OP_DIVERGE = 3'd5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [WW-1:0] cmd_warp = '0;
   logic [PW-1:0] cmd_next_pc = '0;
   logic [PW-1:0] cmd_reconv_pc = '0;
   logic [TW-1:0] cmd_mask = '0;
   logic [PW-1:0] cmd_taken_pc = '0;
   logic [TW-1:0] cmd_taken_mask = '0;
   logic          rsp_valid;
   logic [WW-1:0] rsp_warp;
   logic [PW-1:0] rsp_next_pc;
   logic [PW-1:0] rsp_reconv_pc;
   logic [TW-1:0] rsp_mask;
   logic          rsp_at_reconv;
   logic [NW-1:0] warp_empty;
   logic [NW-1:0] warp_full;
   logic          err_valid;
   logic [1:0]    err_code;

   int n_checks = 0;
   int n_errors = 0;

   simt_stack_mw #(
      .NUM_WARPS(NW), .STACK_DEPTH(SD), .PC_WIDTH(PW), .THREAD_WIDTH(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_warp(cmd_warp), .cmd_next_pc(cmd_next_pc),
      .cmd_reconv_pc(cmd_reconv_pc), .cmd_mask(cmd_mask),
      .cmd_taken_pc(cmd_taken_pc), .cmd_taken_mask(cmd_taken_mask),
      .rsp_valid(rsp_valid), .rsp_warp(rsp_warp), .rsp_next_pc(rsp_next_pc),
      .rsp_reconv_pc(rsp_reconv_pc), .rsp_mask(rsp_mask),
      .rsp_at_reconv(rsp_at_reconv), .warp_empty(warp_empty),
      .warp_full(warp_full), .err_valid(err_valid), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer one command for one cycle; returns 1 ns after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [WW-1:0] w,
                        input logic [PW-1:0] npc = '0, input logic [PW-1:0] rpc = '0,
                        input logic [TW-1:0] msk = '0, input logic [PW-1:0] tpc = '0,
                        input logic [TW-1:0] tmsk = '0);
      int guard = 0;
      while (!cmd_ready && guard < 8) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard == 8) check("ready_timeout", {255'd0, cmd_ready}, 256'd1);
      cmd_valid      = 1'b1;
      cmd_op         = op;
      cmd_warp       = w;
      cmd_next_pc    = npc;
      cmd_reconv_pc  = rpc;
      cmd_mask       = msk;
      cmd_taken_pc   = tpc;
      cmd_taken_mask = tmsk;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_empty", warp_empty, 8'hFF);
      check("rst_full",  warp_full,  8'h00);
      check("rst_ready", cmd_ready,  1'b1);
      check("rst_rsp",   rsp_valid,  1'b0);
      check("rst_err",   err_valid,  1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // PUSH warp 3 then READ back-to-back
      issue(OP_PUSH, 3'd3, 64'h1000, 64'h2000, 256'h1);
      check("push3_empty", warp_empty, 8'hF7);
      check("push3_err",   err_valid,  1'b0);
      issue(OP_READ, 3'd3);
      check("rd3_valid",  rsp_valid,     1'b1);
      check("rd3_warp",   rsp_warp,      3'd3);
      check("rd3_pc",     rsp_next_pc,   64'h1000);
      check("rd3_reconv", rsp_reconv_pc, 64'h2000);
      check("rd3_mask",   rsp_mask,      256'h1);
      check("rd3_atrc",   rsp_at_reconv, 1'b0);
      idle_cycle();
      check("rd3_pulse",  rsp_valid,     1'b0);

      // DIVERGE warp 1: taken path on top
      issue(OP_DIVERGE, 3'd1, 64'h1100, 64'h3000, 256'h0F, 64'h1200, 256'hF0);
      check("div_busy",   cmd_ready, 1'b0);
      idle_cycle();
      check("div_ready",  cmd_ready, 1'b1);
      check("div_empty",  warp_empty, 8'hF5);
      issue(OP_READ, 3'd1);
      check("div_rd_pc",     rsp_next_pc,   64'h1200);
      check("div_rd_mask",   rsp_mask,      256'hF0);
      check("div_rd_reconv", rsp_reconv_pc, 64'h3000);
      issue(OP_POP, 3'd1);
      issue(OP_READ, 3'd1);
      check("div_rd2_valid", rsp_valid,   1'b1);
      check("div_rd2_pc",    rsp_next_pc, 64'h1100);
      check("div_rd2_mask",  rsp_mask,    256'h0F);
      issue(OP_POP, 3'd1);
      check("div_pop_empty", warp_empty, 8'hF7);

      // Fill warp 0 to full, then overflow
      for (int i = 0; i < SD; i++)
         issue(OP_PUSH, 3'd0, PW'(i), PW'(32'h100 + i), TW'(i));
      check("fill_full",  warp_full,  8'h01);
      check("fill_empty", warp_empty, 8'hF6);
      issue(OP_PUSH, 3'd0, 64'hDEAD, 64'hBEEF, 256'hABC);
      check("ovf_valid", err_valid, 1'b1);
      check("ovf_code",  err_code,  2'd1);
      issue(OP_READ, 3'd0);
      check("ovf_top_pc",     rsp_next_pc,   64'h1F);
      check("ovf_top_reconv", rsp_reconv_pc, 64'h11F);
      check("ovf_top_mask",   rsp_mask,      256'h1F);
      issue(OP_POP, 3'd0);
      check("pop_notfull", warp_full, 8'h00);
      issue(OP_DIVERGE, 3'd0, 64'h1, 64'h2, 256'h3, 64'h4, 256'h5);
      check("divovf_valid", err_valid, 1'b1);
      check("divovf_code",  err_code,  2'd1);
      check("divovf_ready", cmd_ready, 1'b1);
      idle_cycle();
      check("divovf_full", warp_full, 8'h00);
      issue(OP_READ, 3'd0);
      check("divovf_top_pc", rsp_next_pc, 64'h1E);

      // Errors on empty warp 5
      issue(OP_POP, 3'd5);
      check("pop5_valid", err_valid, 1'b1);
      check("pop5_code",  err_code,  2'd2);
      issue(OP_MODIFY, 3'd5, 64'h7, 64'h7, 256'h7);
      check("mod5_code",  err_code,  2'd3);
      issue(OP_READ, 3'd5);
      check("rd5_code",   err_code,  2'd3);
      check("rd5_rsp",    rsp_valid, 1'b0);
      check("w5_empty",   warp_empty[5], 1'b1);

      // MODIFY warp 2 top so it sits at its reconvergence point
      issue(OP_PUSH, 3'd2, 64'h5000, 64'h6000, 256'h3);
      issue(OP_MODIFY, 3'd2, 64'h4000, 64'h4000, 256'hFF);
      check("mod2_err", err_valid, 1'b0);
      issue(OP_READ, 3'd2);
      check("mod2_pc",   rsp_next_pc,   64'h4000);
      check("mod2_mask", rsp_mask,      256'hFF);
      check("mod2_atrc", rsp_at_reconv, 1'b1);
      issue(3'd6, 3'd2);
      check("rsvd_err", err_valid, 1'b0);
      check("rsvd_rsp", rsp_valid, 1'b0);

      // Reset asserted during DIV2 abandons the second push
      issue(OP_DIVERGE, 3'd4, 64'h10, 64'h20, 256'h1, 64'h30, 256'h2);
      check("rstdiv_busy", cmd_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rstdiv_empty", warp_empty, 8'hFF);
      check("rstdiv_ready", cmd_ready,  1'b1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(OP_READ, 3'd4);
      check("rstdiv_rd_err", err_code,  2'd3);
      check("rstdiv_rd_rsp", rsp_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
